mult_ctrl: RTL and testbench

Sequencing controller for the two-stage Booth/Wallace multiplier core (`multCore`) in the CPU execute stage. It accepts multiply-class instructions from the pipeline over a valid/ready handshake and drives the core's operands and sign mode. It captures the product one cycle after issue and performs the accumulate step for MADD/MSUB. It owns the architectural HI/LO registers and returns a 32-bit result to the pipeline.

---
 rtl/mult_ctrl.sv | 152 +++++++++++++++
 tb/tb_mult_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing controller for the two-stage multiplier core: issues operands, captures the
// product one cycle later, performs the MADD/MSUB accumulate and owns the HI/LO registers.
module mult_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        flush,
  output logic [31:0] mc_op1,
  output logic [31:0] mc_op2,
  output logic        mc_sign_en,
  input  logic [63:0] mc_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/out_data stay stable until out_ready, and in_ready never depends on in_valid.

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MSUBU = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] hilo_q, hilo_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        issue;
  logic [63:0] acc_sum;

  // The core registers every cycle, so operands are passed straight through.
  assign mc_op1     = in_src1;
  assign mc_op2     = in_src2;
  assign mc_sign_en = (in_op == OP_MULT) || (in_op == OP_MUL) ||
                      (in_op == OP_MADD) || (in_op == OP_MSUB);

  assign in_ready = ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready)) && !flush;
  assign issue    = in_valid && in_ready;

  assign acc_sum = ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) ? (hilo_q - prod_q)
                                                             : (hilo_q + prod_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    prod_d      = prod_q;
    hilo_d      = hilo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_CALC;
          op_d    = in_op;
        end
      end
      S_CALC: begin
        prod_d = mc_out;
        case (op_q)
          OP_MULT, OP_MULTU: begin
            hilo_d      = mc_out;
            out_data_d  = mc_out[31:0];
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
          OP_MUL: begin
            out_data_d  = mc_out[31:0];
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
          OP_NOP: begin
            out_data_d  = 32'd0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
          default: state_d = S_ACC;
        endcase
      end
      S_ACC: begin
        hilo_d      = acc_sum;
        out_data_d  = acc_sum[31:0];
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (issue) begin
            state_d = S_CALC;
            op_d    = in_op;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything: abandon the op and drop any HI/LO write this cycle.
    if (flush) begin
      state_d     = S_IDLE;
      op_d        = op_q;
      hilo_d      = hilo_q;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      prod_q      <= 64'd0;
      hilo_q      <= 64'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      prod_q      <= prod_d;
      hilo_q      <= hilo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign hi          = hilo_q[63:32];
  assign lo          = hilo_q[31:0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural two-stage multiplier core attached.
module tb_mult_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic        flush;
  logic [31:0] mc_op1, mc_op2;
  logic        mc_sign_en;
  logic [63:0] mc_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  mult_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .flush       (flush),
    .mc_op1      (mc_op1),
    .mc_op2      (mc_op2),
    .mc_sign_en  (mc_sign_en),
    .mc_out      (mc_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core stand-in: registered 32x32 product, signed when sign_en is set.
  always_ff @(posedge clk) begin
    if (mc_sign_en)
      mc_out <= $signed({{32{mc_op1[31]}}, mc_op1}) * $signed({{32{mc_op2[31]}}, mc_op2});
    else
      mc_out <= {32'd0, mc_op1} * {32'd0, mc_op2};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request; returns 1 time unit after the accepting edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    #1;
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = OP_NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_NOP;
    in_src1   = 32'd0;
    in_src2   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step(2);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    rstn = 1'b1;
    step(1);

    // MULT -1 x 2
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("mult_e0_valid", {63'd0, out_valid}, 64'd0);
    chk("mult_e0_state", {62'd0, dbg_state}, {62'd0, ST_CALC});
    step(1);
    chk("mult_valid", {63'd0, out_valid}, 64'd1);
    chk("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
    chk("mult_data", {32'd0, out_data}, 64'h0000_0000_FFFF_FFFE);
    step(1);
    chk("mult_idle_valid", {63'd0, out_valid}, 64'd0);
    chk("mult_idle_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    step(1);
    chk("multu_hi", {32'd0, hi}, 64'd1);
    chk("multu_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
    step(1);

    // hi:lo = 0:FFFFFFFF, then accumulate chain
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0001);
    step(1);
    chk("seed_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    step(1);
    issue(OP_MADDU, 32'd1, 32'd1);
    chk("maddu_e0_valid", {63'd0, out_valid}, 64'd0);
    step(1);
    chk("maddu_e1_valid", {63'd0, out_valid}, 64'd0);
    chk("maddu_e1_state", {62'd0, dbg_state}, {62'd0, ST_ACC});
    step(1);
    chk("maddu_valid", {63'd0, out_valid}, 64'd1);
    chk("maddu_hi", {32'd0, hi}, 64'd1);
    chk("maddu_lo", {32'd0, lo}, 64'd0);
    chk("maddu_data", {32'd0, out_data}, 64'd0);
    step(1);
    issue(OP_MSUB, 32'd1, 32'd1);
    step(2);
    chk("msub_hi", {32'd0, hi}, 64'd0);
    chk("msub_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    chk("msub_data", {32'd0, out_data}, 64'h0000_0000_FFFF_FFFF);
    step(1);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
    step(2);
    chk("msub_neg_hi", {32'd0, hi}, 64'd1);
    chk("msub_neg_lo", {32'd0, lo}, 64'd0);
    step(1);

    // hi:lo = 12345678:9ABCDEF0 (0x2468ACF0 * 2^31 == 0x12345678 << 32)
    issue(OP_MULTU, 32'h9ABC_DEF0, 32'd1);
    step(2);
    issue(OP_MADDU, 32'h2468_ACF0, 32'h8000_0000);
    step(2);
    chk("seed2_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    chk("seed2_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);
    step(1);
    issue(OP_MUL, 32'h0001_0001, 32'h0001_0001);
    step(1);
    chk("mul_valid", {63'd0, out_valid}, 64'd1);
    chk("mul_data", {32'd0, out_data}, 64'h0000_0000_0002_0001);
    chk("mul_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    chk("mul_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);
    step(1);
    issue(OP_NOP, 32'd5, 32'd5);
    step(1);
    chk("nop_valid", {63'd0, out_valid}, 64'd1);
    chk("nop_data", {32'd0, out_data}, 64'd0);
    chk("nop_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    step(1);

    // Flush in CALC
    issue(OP_MULT, 32'd3, 32'd4);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", {63'd0, in_ready}, 64'd0);
    step(1);
    flush = 1'b0;
    #1;
    chk("flush_calc_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    chk("flush_calc_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_calc_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    chk("flush_calc_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);
    chk("flush_calc_ready", {63'd0, in_ready}, 64'd1);
    step(1);
    chk("flush_calc_valid2", {63'd0, out_valid}, 64'd0);

    // Flush in ACC
    issue(OP_MADD, 32'd3, 32'd4);
    step(1);
    chk("flush_acc_state", {62'd0, dbg_state}, {62'd0, ST_ACC});
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_acc_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    chk("flush_acc_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);
    chk("flush_acc_valid", {63'd0, out_valid}, 64'd0);
    step(1);
    chk("flush_acc_valid2", {63'd0, out_valid}, 64'd0);

    // Backpressure then back-to-back accept
    out_ready = 1'b0;
    issue(OP_MULT, 32'd5, 32'd6);
    step(1);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_data", {32'd0, out_data}, 64'd30);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_data", {32'd0, out_data}, 64'd30);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    issue(OP_MULT, 32'd7, 32'd8);
    chk("b2b_state", {62'd0, dbg_state}, {62'd0, ST_CALC});
    chk("b2b_valid", {63'd0, out_valid}, 64'd0);
    step(1);
    chk("b2b_lo", {32'd0, lo}, 64'd56);
    chk("b2b_hi", {32'd0, hi}, 64'd0);
    chk("b2b_data", {32'd0, out_data}, 64'd56);
    chk("b2b_valid2", {63'd0, out_valid}, 64'd1);
    step(1);

    // Async reset in ACC
    issue(OP_MADD, 32'd2, 32'd3);
    step(1);
    chk("rst_acc_state", {62'd0, dbg_state}, {62'd0, ST_ACC});
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_data", {32'd0, out_data}, 64'd0);
    chk("arst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    step(1);
    rstn = 1'b1;
    step(1);
    issue(OP_MULT, 32'd9, 32'd9);
    step(1);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_lo", {32'd0, lo}, 64'd81);
    chk("post_rst_hi", {32'd0, hi}, 64'd0);
    chk("post_rst_data", {32'd0, out_data}, 64'd81);
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
